// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and fixed-timing access sequencer for one
// asynchronous SRAM bank. Strobes and bus enable are registered from the next state.
module sram_arbiter #(
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_ce,
    output logic                  ram_oe,
    output logic                  ram_we
);

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

    state_t                state;
    state_t                next_state;
    logic [7:0]            cnt;
    logic [7:0]            cnt_next;
    logic                  grant;
    logic                  grant_port;
    logic                  owner;
    logic                  last_grant;
    logic                  done;
    logic                  drive;
    logic [DATA_WIDTH-1:0] wdata_q;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        grant      = 1'b0;
        grant_port = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant      = 1'b1;
                    // On a tie the port that did not win last time is served.
                    grant_port = (req0 && req1) ? ~last_grant : req1;
                    next_state = (grant_port ? we1 : we0) ? WR_SETUP : RD;
                    cnt_next   = '0;
                end
            end
            RD: begin
                if (cnt == 8'(READ_CYCLES - 1)) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            WR_SETUP: begin
                next_state = WR_PULSE;
                cnt_next   = '0;
            end
            WR_PULSE: begin
                if (cnt == 8'(WRITE_CYCLES - 1)) begin
                    next_state = WR_HOLD;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            WR_HOLD: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            ram_addr   <= '0;
            wdata_q    <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            ram_ce     <= 1'b1;
            ram_oe     <= 1'b1;
            ram_we     <= 1'b1;
            drive      <= 1'b0;
        end else begin
            if (grant) begin
                owner      <= grant_port;
                last_grant <= grant_port;
                ram_addr   <= grant_port ? addr1 : addr0;
                wdata_q    <= grant_port ? wdata1 : wdata0;
            end
            ack0 <= done && !owner;
            ack1 <= done && owner;
            if (done && state == RD) begin
                if (owner) begin
                    rdata1 <= ram_data;
                end else begin
                    rdata0 <= ram_data;
                end
            end
            // Registering from next_state keeps strobes glitch-free yet aligned with the state.
            ram_ce <= (next_state == IDLE);
            ram_oe <= (next_state != RD);
            ram_we <= (next_state != WR_PULSE);
            drive  <= (next_state == WR_SETUP) || (next_state == WR_PULSE) ||
                      (next_state == WR_HOLD);
        end
    end

    assign ram_data = drive ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: default timing on one instance,
// READ_CYCLES=1 / WRITE_CYCLES=3 on a second, each with its own SRAM model.
module tb_sram_arbiter;
    localparam int AW = 20;
    localparam int DW = 32;

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
        int            at;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1;
    logic          ack0, ack1, ram_ce, ram_oe, ram_we;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;

    logic          req0_b, req1_b, we0_b, we1_b;
    logic [AW-1:0] addr0_b, addr1_b;
    logic [DW-1:0] wdata0_b, wdata1_b, rdata0_b, rdata1_b;
    logic          ack0_b, ack1_b, ram_ce_b, ram_oe_b, ram_we_b;
    logic [AW-1:0] ram_addr_b;
    wire  [DW-1:0] ram_data_b;

    logic [DW-1:0] mem   [0:255];
    logic [DW-1:0] mem_b [0:255];
    logic          pl_en;
    logic [7:0]    pl_addr;
    logic [DW-1:0] pl_data;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    sram_arbiter u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .rdata0(rdata0), .rdata1(rdata1), .ack0(ack0), .ack1(ack1),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we)
    );

    sram_arbiter #(.READ_CYCLES(1), .WRITE_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0(req0_b), .req1(req1_b), .we0(we0_b), .we1(we1_b),
        .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
        .rdata0(rdata0_b), .rdata1(rdata1_b), .ack0(ack0_b), .ack1(ack1_b),
        .ram_addr(ram_addr_b), .ram_data(ram_data_b),
        .ram_ce(ram_ce_b), .ram_oe(ram_oe_b), .ram_we(ram_we_b)
    );

    // Asynchronous SRAM models: drive the bus while ce/oe are low, store while ce/we are low.
    assign ram_data   = (!ram_ce && !ram_oe) ? mem[ram_addr[7:0]] : 'z;
    assign ram_data_b = (!ram_ce_b && !ram_oe_b) ? mem_b[ram_addr_b[7:0]] : 'z;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) begin
            mem[pl_addr]   <= pl_data;
            mem_b[pl_addr] <= pl_data;
        end else begin
            if (!ram_ce && !ram_we) mem[ram_addr[7:0]] <= ram_data;
            if (!ram_ce_b && !ram_we_b) mem_b[ram_addr_b[7:0]] <= ram_data_b;
        end
    end

    task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Drive one request (at a negedge) and queue the bench-computed completion.
    task automatic issue(input bit b, input bit p, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int lat, input logic [DW-1:0] exp_data);
        sb.push_back('{port: p, data: exp_data, at: cyc + 1 + lat});
        if (!b && !p) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        if (!b && p)  begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        if (b && !p)  begin req0_b = 1'b1; we0_b = w; addr0_b = a; wdata0_b = d; end
        if (b && p)   begin req1_b = 1'b1; we1_b = w; addr1_b = a; wdata1_b = d; end
    endtask

    task automatic drop_reqs();
        req0 = 1'b0; req1 = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
    endtask

    task automatic wait_ack(input bit b, input int budget, output bit seen, output bit port,
                            output logic [DW-1:0] data, output int at, output int oe_lo,
                            output int we_lo, output bit clash);
        logic a0, a1, oe, we;
        seen = 1'b0; port = 1'b0; data = '0; at = 0; oe_lo = 0; we_lo = 0; clash = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            a0 = b ? ack0_b : ack0;
            a1 = b ? ack1_b : ack1;
            oe = b ? ram_oe_b : ram_oe;
            we = b ? ram_we_b : ram_we;
            if (!oe) oe_lo++;
            if (!we) we_lo++;
            if ((a0 && a1) || (!oe && !we)) clash = 1'b1;
            if (a0 || a1) begin
                seen = 1'b1;
                port = a1;
                data = b ? (a1 ? rdata1_b : rdata0_b) : (a1 ? rdata1 : rdata0);
                at   = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({ram_ce, ram_oe, ram_we, ack0, ack1} !== 5'b11100) begin
            errors++; $display("FAIL reset_strobes: got %b expected 11100", {ram_ce, ram_oe, ram_we, ack0, ack1});
        end
        checks++;
        if ({rdata0, rdata1, ram_addr} !== '0) begin
            errors++; $display("FAIL reset_regs: got rdata0=%h rdata1=%h addr=%h expected all 0", rdata0, rdata1, ram_addr);
        end
        checks++;
        if ({ram_ce_b, ram_oe_b, ram_we_b, ack0_b, ack1_b} !== 5'b11100) begin
            errors++; $display("FAIL reset_strobes_b: got %b expected 11100", {ram_ce_b, ram_oe_b, ram_we_b, ack0_b, ack1_b});
        end
        preload(8'h00, 32'hA000_0000);
        preload(8'h01, 32'hA000_0001);
        preload(8'h02, 32'hA000_0002);
        preload(8'h03, 32'hCAFE_F00D);
        preload(8'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_read();
        bit seen, port, clash; logic [DW-1:0] data; int at, oe_lo, we_lo; exp_t e;
        @(negedge clk);
        issue(1'b0, 1'b1, 1'b0, 20'h00010, '0, 2, 32'hDEAD_BEEF);
        wait_ack(1'b0, 20, seen, port, data, at, oe_lo, we_lo, clash);
        drop_reqs();
        e = sb.pop_front();
        checks++;
        if (!seen || {port, data} !== {e.port, e.data}) begin
            errors++; $display("FAIL rd1_data: got seen=%0d port=%0d data=%h expected port=%0d data=%h", seen, port, data, e.port, e.data);
        end
        checks++;
        if (at !== e.at) begin errors++; $display("FAIL rd1_latency: got cycle %0d expected %0d", at, e.at); end
        checks++;
        if (oe_lo !== 2) begin errors++; $display("FAIL rd1_oe_width: got %0d expected 2", oe_lo); end
        checks++;
        if (rdata0 !== 32'h0) begin errors++; $display("FAIL rd1_rdata0_kept: got %h expected 0", rdata0); end
        checks++;
        if (clash) begin errors++; $display("FAIL rd1_clash: got 1 expected 0"); end
    endtask

    task automatic test_single_write();
        bit seen, port, clash; logic [DW-1:0] data; int at, oe_lo, we_lo; exp_t e;
        logic [AW-1:0] ra [2];
        logic [DW-1:0] rd [2];
        ra[0] = 20'h00010; rd[0] = 32'hDEAD_BEEF;
        ra[1] = 20'h00004; rd[1] = 32'h1234_5678;
        @(negedge clk);
        issue(1'b0, 1'b0, 1'b1, 20'h00004, 32'h1234_5678, 4, 32'h0);
        @(negedge clk);
        drop_reqs(); addr0 = '1; wdata0 = '1;
        wait_ack(1'b0, 20, seen, port, data, at, oe_lo, we_lo, clash);
        e = sb.pop_front();
        checks++;
        if (!seen || {port, data} !== {e.port, e.data}) begin
            errors++; $display("FAIL wr0_ack: got seen=%0d port=%0d rdata=%h expected port=%0d rdata=%h", seen, port, data, e.port, e.data);
        end
        checks++;
        if (at !== e.at) begin errors++; $display("FAIL wr0_latency: got cycle %0d expected %0d", at, e.at); end
        checks++;
        if ({we_lo, oe_lo} !== {32'd2, 32'd0}) begin
            errors++; $display("FAIL wr0_strobes: got we_low=%0d oe_low=%0d expected 2 and 0", we_lo, oe_lo);
        end
        // A bus still driven after the write would corrupt the first read-back.
        for (int k = 0; k < 2; k++) begin
            issue(1'b0, 1'b0, 1'b0, ra[k], '0, 2, rd[k]);
            wait_ack(1'b0, 20, seen, port, data, at, oe_lo, we_lo, clash);
            drop_reqs();
            e = sb.pop_front();
            checks++;
            if (!seen || {port, data, at} !== {e.port, e.data, e.at}) begin
                errors++; $display("FAIL wr0_readback%0d: got port=%0d data=%h cycle=%0d expected port=%0d data=%h cycle=%0d", k, port, data, at, e.port, e.data, e.at);
            end
        end
    endtask

    task automatic test_contention();
        bit seen, port, clash, extra; logic [DW-1:0] data; int at, oe_lo, we_lo, start; exp_t e;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        start = cyc;
        for (int k = 0; k < 6; k++) begin
            sb.push_back('{port: k[0], data: k[0] ? 32'hA000_0001 : 32'hA000_0000, at: start + 3 + 3 * k});
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 20'h0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 20'h1;
        for (int k = 0; k < 6; k++) begin
            wait_ack(1'b0, 20, seen, port, data, at, oe_lo, we_lo, clash);
            if (k == 5) drop_reqs();
            e = sb.pop_front();
            checks++;
            if (!seen || clash || {port, data, at} !== {e.port, e.data, e.at}) begin
                errors++; $display("FAIL rr_grant%0d: got seen=%0d clash=%0d port=%0d data=%h cycle=%0d expected port=%0d data=%h cycle=%0d", k, seen, clash, port, data, at, e.port, e.data, e.at);
            end
        end
        extra = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack0 || ack1) extra = 1'b1;
        end
        checks++;
        if (extra) begin errors++; $display("FAIL rr_extra_ack: got 1 expected 0"); end
    endtask

    task automatic test_back_to_back();
        bit seen, port, clash; logic [DW-1:0] data; int at, oe_lo, we_lo, start; exp_t e;
        logic [DW-1:0] want [3];
        want[0] = 32'hA000_0000; want[1] = 32'hA000_0001; want[2] = 32'hA000_0002;
        @(negedge clk);
        start = cyc;
        for (int k = 0; k < 3; k++) sb.push_back('{port: 1'b1, data: want[k], at: start + 3 + 3 * k});
        req1 = 1'b1; we1 = 1'b0; addr1 = 20'h0;
        for (int k = 0; k < 3; k++) begin
            wait_ack(1'b0, 20, seen, port, data, at, oe_lo, we_lo, clash);
            addr1 = AW'(k + 1);
            if (k == 2) drop_reqs();
            e = sb.pop_front();
            checks++;
            if (!seen || {port, data, at} !== {e.port, e.data, e.at}) begin
                errors++; $display("FAIL b2b_read%0d: got port=%0d data=%h cycle=%0d expected port=%0d data=%h cycle=%0d", k, port, data, at, e.port, e.data, e.at);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bit seen, port, clash, hit; logic [DW-1:0] data; int at, oe_lo, we_lo; exp_t e;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 20'h8; wdata0 = 32'h5555_AAAA;
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 20'h00010;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (!ram_we) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rst_wr_pulse: got no we pulse expected one within 10 cycles"); end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({ram_ce, ram_oe, ram_we, ack0, ack1} !== 5'b11100) begin
            errors++; $display("FAIL rst_wr_abort: got %b expected 11100", {ram_ce, ram_oe, ram_we, ack0, ack1});
        end
        @(negedge clk);
        checks++;
        if ({ram_ce, ack0} !== 2'b10) begin
            errors++; $display("FAIL rst_wr_held: got ce/ack0 %b expected 10", {ram_ce, ack0});
        end
        rst = 1'b1;
        sb.push_back('{port: 1'b1, data: 32'hDEAD_BEEF, at: cyc + 3});
        wait_ack(1'b0, 20, seen, port, data, at, oe_lo, we_lo, clash);
        drop_reqs();
        e = sb.pop_front();
        checks++;
        if (!seen || {port, data, at} !== {e.port, e.data, e.at}) begin
            errors++; $display("FAIL rst_wr_resume: got port=%0d data=%h cycle=%0d expected port=%0d data=%h cycle=%0d", port, data, at, e.port, e.data, e.at);
        end
    endtask

    task automatic test_param_sweep();
        bit seen, port, clash; logic [DW-1:0] data; int at, oe_lo, we_lo; exp_t e;
        @(negedge clk);
        issue(1'b1, 1'b0, 1'b0, 20'h3, '0, 1, 32'hCAFE_F00D);
        wait_ack(1'b1, 20, seen, port, data, at, oe_lo, we_lo, clash);
        drop_reqs();
        e = sb.pop_front();
        checks++;
        if (!seen || {port, data, at, oe_lo} !== {e.port, e.data, e.at, 32'd1}) begin
            errors++; $display("FAIL sweep_read: got port=%0d data=%h cycle=%0d oe_low=%0d expected port=%0d data=%h cycle=%0d oe_low=1", port, data, at, oe_lo, e.port, e.data, e.at);
        end
        issue(1'b1, 1'b0, 1'b1, 20'h5, 32'h0BAD_BEEF, 5, 32'hCAFE_F00D);
        wait_ack(1'b1, 20, seen, port, data, at, oe_lo, we_lo, clash);
        drop_reqs();
        e = sb.pop_front();
        checks++;
        if (!seen || {port, data, at} !== {e.port, e.data, e.at}) begin
            errors++; $display("FAIL sweep_write: got port=%0d rdata=%h cycle=%0d expected port=%0d rdata=%h cycle=%0d", port, data, at, e.port, e.data, e.at);
        end
        checks++;
        if (we_lo !== 3) begin errors++; $display("FAIL sweep_we_width: got %0d expected 3", we_lo); end
        issue(1'b1, 1'b0, 1'b0, 20'h5, '0, 1, 32'h0BAD_BEEF);
        wait_ack(1'b1, 20, seen, port, data, at, oe_lo, we_lo, clash);
        drop_reqs();
        e = sb.pop_front();
        checks++;
        if (!seen || {port, data, at} !== {e.port, e.data, e.at}) begin
            errors++; $display("FAIL sweep_readback: got port=%0d data=%h cycle=%0d expected port=%0d data=%h cycle=%0d", port, data, at, e.port, e.data, e.at);
        end
    endtask

    initial begin
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        req0_b = 1'b0; req1_b = 1'b0; we0_b = 1'b0; we1_b = 1'b0;
        addr0_b = '0; addr1_b = '0; wdata0_b = '0; wdata1_b = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_back_to_back();
        test_reset_mid_write();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
